// File: rtl/multicycle_pkg.sv
// Shared encodings for the multi-cycle RISC-V control unit: FSM states, opcodes,
// ALU operation classes, ALU B-source selects and the decoded control vector.
package multicycle_pkg;

    localparam int STATE_BITS = 4;

    typedef enum logic [STATE_BITS-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_MEM_ADDR = 4'd4,
        S_MEM_RD   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_WB_ALU   = 4'd7,
        S_WB_MEM   = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10,
        S_TRAP     = 4'd11
    } state_e;

    localparam logic [6:0] ALU_R     = 7'b0110011;
    localparam logic [6:0] ALU_I     = 7'b0010011;
    localparam logic [6:0] BRANCH_EQ = 7'b1100011;
    localparam logic [6:0] JUMP      = 7'b1101111;
    localparam logic [6:0] LOAD      = 7'b0000011;
    localparam logic [6:0] STORE     = 7'b0100011;

    localparam logic [1:0] ADD_OPCODE    = 2'b00;
    localparam logic [1:0] SUB_OPCODE    = 2'b01;
    localparam logic [1:0] R_TYPE_OPCODE = 2'b10;

    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_FOUR = 2'b01;
    localparam logic [1:0] SRC_B_IMM  = 2'b10;

    typedef struct packed {
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       mem_2_reg;
        logic       reg_write;
        logic       jump;
    } ctrl_t;

    function automatic state_e decode_opcode(input logic [6:0] op);
        case (op)
            ALU_R:       return S_EXEC_R;
            ALU_I:       return S_EXEC_I;
            LOAD, STORE: return S_MEM_ADDR;
            BRANCH_EQ:   return S_BRANCH;
            JUMP:        return S_JUMP;
            default:     return S_TRAP;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Bundle between the control unit (slave side) and the multi-cycle datapath
// (master side): opcode/handshake inputs and all control outputs.
interface multicycle_control_unit_if #(
    parameter int ALU_OP_W = 2,
    parameter int CNT_W    = 32,
    parameter int STATE_W  = 4
);
    logic                enable;
    logic [6:0]          opcode;
    logic                mem_ready;
    logic                ir_write;
    logic                pc_write;
    logic                pc_write_cond;
    logic                i_or_d;
    logic                mem_read;
    logic                mem_write;
    logic                alu_src_a;
    logic [1:0]          alu_src_b;
    logic [ALU_OP_W-1:0] alu_op;
    logic                mem_2_reg;
    logic                reg_write;
    logic                jump;
    logic                illegal;
    logic [STATE_W-1:0]  state;
    logic [CNT_W-1:0]    retired;

    modport slave (
        input  enable, opcode, mem_ready,
        output ir_write, pc_write, pc_write_cond, i_or_d, mem_read, mem_write,
               alu_src_a, alu_src_b, alu_op, mem_2_reg, reg_write, jump,
               illegal, state, retired
    );

    modport master (
        output enable, opcode, mem_ready,
        input  ir_write, pc_write, pc_write_cond, i_or_d, mem_read, mem_write,
               alu_src_a, alu_src_b, alu_op, mem_2_reg, reg_write, jump,
               illegal, state, retired
    );
endinterface

// File: rtl/multicycle_control_unit_output_decode.sv
// Moore output decode: state -> datapath control vector, with the write/request
// strobes suppressed while the unit is frozen.
module mc_output_decode
    import multicycle_pkg::*;
(
    input  state_e state,
    input  logic   enable,
    input  logic   mem_ready,
    output ctrl_t  ctrl
);
    always_comb begin
        ctrl        = '0;
        ctrl.alu_op = ADD_OPCODE;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRC_B_FOUR;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: ctrl.alu_src_b = SRC_B_IMM;
            S_EXEC_R: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRC_B_RS2;
                ctrl.alu_op    = R_TYPE_OPCODE;
            end
            S_EXEC_I, S_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRC_B_IMM;
            end
            S_MEM_RD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            S_MEM_WR: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
            end
            S_WB_ALU: ctrl.reg_write = 1'b1;
            S_WB_MEM: begin
                ctrl.reg_write = 1'b1;
                ctrl.mem_2_reg = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRC_B_RS2;
                ctrl.alu_op        = SUB_OPCODE;
                ctrl.pc_write_cond = 1'b1;
            end
            S_JUMP: begin
                ctrl.jump     = 1'b1;
                ctrl.pc_write = 1'b1;
            end
            default: ;
        endcase
        // A frozen unit must not issue memory requests or commit any state.
        if (!enable) begin
            ctrl.ir_write      = 1'b0;
            ctrl.pc_write      = 1'b0;
            ctrl.pc_write_cond = 1'b0;
            ctrl.mem_read      = 1'b0;
            ctrl.mem_write     = 1'b0;
            ctrl.reg_write     = 1'b0;
        end
    end
endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RISC-V control FSM: state register, next-state logic, sticky
// illegal-opcode trap flag and retired-instruction counter.
module multicycle_control_unit
    import multicycle_pkg::*;
#(
    parameter int ALU_OP_W = 2,
    parameter int CNT_W    = 32,
    parameter int STATE_W  = 4
) (
    input  logic                      clk,
    input  logic                      arst_n,
    multicycle_control_unit_if.slave  bus
);
    state_e           state_q, state_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             illegal_q, illegal_d;
    logic             retire;
    ctrl_t            ctrl;

    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        if (bus.enable) begin
            case (state_q)
                S_FETCH:    if (bus.mem_ready) state_d = S_DECODE;
                S_DECODE:   state_d = decode_opcode(bus.opcode);
                S_EXEC_R,
                S_EXEC_I:   state_d = S_WB_ALU;
                // IR is stable here, so re-reading the opcode picks load vs store.
                S_MEM_ADDR: state_d = (bus.opcode == LOAD) ? S_MEM_RD : S_MEM_WR;
                S_MEM_RD:   if (bus.mem_ready) state_d = S_WB_MEM;
                S_MEM_WR: begin
                    if (bus.mem_ready) begin
                        state_d = S_FETCH;
                        retire  = 1'b1;
                    end
                end
                S_WB_ALU, S_WB_MEM, S_BRANCH, S_JUMP: begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end
                S_TRAP:     state_d = S_TRAP;
                default:    state_d = S_FETCH;
            endcase
        end
        retired_d = retired_q + CNT_W'(retire);
        illegal_d = illegal_q | (state_d == S_TRAP);
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q   <= S_FETCH;
            retired_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
            illegal_q <= illegal_d;
        end
    end

    mc_output_decode u_output_decode (
        .state     (state_q),
        .enable    (bus.enable),
        .mem_ready (bus.mem_ready),
        .ctrl      (ctrl)
    );

    assign bus.ir_write      = ctrl.ir_write;
    assign bus.pc_write      = ctrl.pc_write;
    assign bus.pc_write_cond = ctrl.pc_write_cond;
    assign bus.i_or_d        = ctrl.i_or_d;
    assign bus.mem_read      = ctrl.mem_read;
    assign bus.mem_write     = ctrl.mem_write;
    assign bus.alu_src_a     = ctrl.alu_src_a;
    assign bus.alu_src_b     = ctrl.alu_src_b;
    assign bus.alu_op        = ALU_OP_W'(ctrl.alu_op);
    assign bus.mem_2_reg     = ctrl.mem_2_reg;
    assign bus.reg_write     = ctrl.reg_write;
    assign bus.jump          = ctrl.jump;
    assign bus.illegal       = illegal_q;
    assign bus.state         = STATE_W'(state_q);
    assign bus.retired       = retired_q;
endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
Moore-style FSM control unit for the multi-cycle RISC-V datapath, the successor of the single-cycle opcode decoder. It sequences each instruction through fetch/decode/execute/memory/writeback steps with a ready handshake on the shared instruction/data memory. It also adds an enable/stall input, a sticky illegal-opcode trap and a retired-instruction counter. It sits between the instruction register opcode field and the multi-cycle datapath muxes and enables.

Parameters:
ALU_OP_W, 2, width of alu_op (00 add, 01 sub, 10 R-type funct decode)
CNT_W, 32, width of retired-instruction counter
STATE_W, 4, width of exported state encoding

Ports:
clk  in  1  clock, rising edge
arst_n  in  1  asynchronous active-low reset
enable  in  1  1 = FSM may advance; 0 = freeze
opcode  in  7  opcode field of instruction register
mem_ready  in  1  memory completed the current read/write this cycle
ir_write  out  1  load instruction register
pc_write  out  1  unconditional PC update
pc_write_cond  out  1  PC update if ALU zero (branch)
i_or_d  out  1  memory address: 0 = PC, 1 = ALU result register
mem_read  out  1  memory read request
mem_write  out  1  memory write request
alu_src_a  out  1  0 = PC, 1 = rs1
alu_src_b  out  2  00 = rs2, 01 = constant 4, 10 = immediate
alu_op  out  ALU_OP_W  ALU operation class
mem_2_reg  out  1  writeback source: 1 = memory data register
reg_write  out  1  register file write enable
jump  out  1  selects jump target for PC
illegal  out  1  sticky illegal-opcode flag
state  out  STATE_W  current FSM state (debug)
retired  out  CNT_W  count of completed instructions

Behaviour:
- Reset (async, arst_n=0): state=FETCH, retired=0, illegal=0. All outputs are decoded from state and take FETCH values immediately (mem_read=1).
- Outputs are a pure function of state, except strobes forced 0 while enable=0. Strobes are ir_write, pc_write, pc_write_cond, mem_read, mem_write, reg_write. Unlisted outputs in a state are 0; alu_op defaults to 00.
- Transitions occur only on a rising clk with enable=1.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00. ir_write=pc_write=mem_ready. Goes to DECODE when mem_ready=1, else holds.
- DECODE: alu_src_a=0, alu_src_b=10, alu_op=00 (branch target). Next state by opcode:
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 0000011 or 0100011 -> MEM_ADDR
  - 1100011 -> BRANCH
  - 1101111 -> JUMP
  - any other -> TRAP
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10 -> WB_ALU.
- EXEC_I: alu_src_a=1, alu_src_b=10, alu_op=00 -> WB_ALU.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Opcode 0000011 -> MEM_RD, else -> MEM_WR. Opcode is re-sampled here; the IR is stable.
- MEM_RD: mem_read=1, i_or_d=1. Holds until mem_ready -> WB_MEM.
- MEM_WR: mem_write=1, i_or_d=1. Holds until mem_ready -> FETCH, retires.
- WB_ALU: reg_write=1, mem_2_reg=0 -> FETCH, retires.
- WB_MEM: reg_write=1, mem_2_reg=1 -> FETCH, retires.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1 -> FETCH, retires.
- JUMP: jump=1, pc_write=1 -> FETCH, retires.
- TRAP: all strobes 0; illegal=1 set on entry, stays set. State is absorbing until reset.
- Retire: retired increments by 1 on the edge leaving a retiring state. It wraps modulo 2^CNT_W with no saturation.
- Cycle counts with mem_ready always 1:
  - R/I-type: 4 cycles
  - load: 5 cycles
  - store: 4 cycles
  - branch/jump: 3 cycles
- mem_ready is ignored in non-memory states.
- enable=0 during FETCH/MEM_RD/MEM_WR: the request drops and a coincident mem_ready is ignored, so the transaction repeats when enable returns.
- Unused state encodings -> next state FETCH.
- Reset mid-instruction aborts the instruction; no retire count.

Decomposition:
- Shared package multicycle_pkg holds:
  - state encodings (STATE_W wide)
  - opcode constants ALU_R, ALU_I, BRANCH_EQ, JUMP, LOAD, STORE
  - alu_op constants ADD_OPCODE, SUB_OPCODE, R_TYPE_OPCODE
  - alu_src_b select constants
- One sub-module: mc_output_decode, combinational state -> control vector plus enable gating.
- The FSM register, next-state logic and counter stay in the top.

Test Plan:
- R-type 0110011, mem_ready=1, enable=1 from reset -> states FETCH, DECODE, EXEC_R, WB_ALU, FETCH; reg_write=1 only in cycle 4; retired 0->1.
- Load 0000011 with mem_ready low 3 cycles in MEM_RD -> mem_read=1, i_or_d=1 held 4 cycles; then WB_MEM with mem_2_reg=1; total 8 cycles; retired=1.
- Branch 1100011 then jump 1101111 -> 3 cycles each; pc_write_cond=1 with alu_op=01 in BRANCH; pc_write=jump=1 in JUMP; retired=2.
- Opcode 1111111 -> TRAP after DECODE; illegal=1; all strobes 0 for 20 cycles; arst_n pulse -> FETCH, illegal=0, retired=0.
- enable=0 in FETCH with mem_ready=1 -> mem_read=ir_write=pc_write=0, state stays FETCH; enable=1 -> DECODE next edge.
- Preload retired via 2^CNT_W-1 retirements (CNT_W=4 instance: 15 R-types) -> 16th retire gives retired=0.
